// File: rtl/memory_writeback_cc.sv
// Memory + writeback end of the 5-stage RISC-V pipeline: word-wide req/ack data-memory
// access with stall and timeout abort, followed by the MEM/WB register feeding the register file.
module memory_writeback_cc #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [4:0]  RDM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        RegWriteW,
  output logic [4:0]  RDW,
  output logic [31:0] ResultW,
  output logic        mem_err
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic TO_EN = (TIMEOUT != 0);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          mem_err_r;
  logic          reg_write_w_r;
  logic [4:0]    rd_w_r;
  logic          result_src_w_r;
  logic [31:0]   alu_result_w_r;
  logic [31:0]   read_data_w_r;

  logic memop_s, req_s, ack_s, abort_s, stall_s;

  // Request, accepted-ack, timeout abort and stall decode; reset masks the request at once.
  always_comb begin
    memop_s = MemWriteM | ResultSrcM;
    req_s   = 1'b0;
    abort_s = 1'b0;
    if (rst) begin
      if (state_r == WAIT) begin
        req_s   = 1'b1;
        abort_s = TO_EN & ~dmem_ack & (cnt_r == CNT_MAX);
      end else begin
        req_s   = memop_s;
        abort_s = 1'b0;
      end
    end else begin
      req_s   = 1'b0;
      abort_s = 1'b0;
    end
    ack_s   = req_s & dmem_ack;
    stall_s = req_s & ~dmem_ack & ~abort_s;
  end

  // Access FSM with wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      mem_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (memop_s && !dmem_ack) begin
            state_r <= WAIT;
            cnt_r   <= CNT_ONE;
          end else begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (abort_s) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            mem_err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // MEM/WB register: a stall inserts a bubble, an aborted load never writes rd.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write_w_r  <= 1'b0;
      rd_w_r         <= 5'd0;
      result_src_w_r <= 1'b0;
      alu_result_w_r <= 32'd0;
      read_data_w_r  <= 32'd0;
    end else if (stall_s) begin
      reg_write_w_r <= 1'b0;
    end else begin
      reg_write_w_r  <= RegWriteM & (RDM != 5'd0) & ~(abort_s & ResultSrcM);
      rd_w_r         <= RDM;
      result_src_w_r <= ResultSrcM;
      alu_result_w_r <= ALUResultM;
      if (ack_s) begin
        read_data_w_r <= dmem_rdata;
      end else begin
        read_data_w_r <= read_data_w_r;
      end
    end
  end

  assign dmem_req   = req_s;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_wdata = WriteDataM;
  assign StallM     = stall_s;
  assign mem_err    = mem_err_r;
  assign RegWriteW  = reg_write_w_r;
  assign RDW        = rd_w_r;
  assign ResultW    = result_src_w_r ? read_data_w_r : alu_result_w_r;

endmodule

// File: tb/tb_memory_writeback_cc.sv
// Self-checking bench for memory_writeback_cc: hand-derived cycle vectors for the
// directed cases, then random traffic against a per-transaction reference model.
module tb_memory_writeback_cc;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, ResultSrcM, MemWriteM;
  logic [4:0]  RDM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        mem_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_writeback_cc #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .RDM(RDM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .mem_err(mem_err)
  );

  typedef struct {
    logic        rst, rw, rs, mw;
    logic [4:0]  rd;
    logic [31:0] alu, wd;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_stall, e_we;
    logic [31:0] e_addr;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_res;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rw, input logic rs, input logic mw,
                              input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                              input logic ack, input logic [31:0] rdata,
                              input logic e_req, input logic e_stall, input logic [31:0] e_addr,
                              input logic e_rw, input logic [4:0] e_rd, input logic [31:0] e_res,
                              input logic e_err);
    vec_t v;
    v.rst = r; v.rw = rw; v.rs = rs; v.mw = mw; v.rd = rd; v.alu = alu; v.wd = wd;
    v.ack = ack; v.rdata = rdata; v.e_req = e_req; v.e_stall = e_stall; v.e_we = mw;
    v.e_addr = e_addr; v.e_rw = e_rw; v.e_rd = e_rd; v.e_res = e_res; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rw, input logic rs, input logic mw,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                       input logic ack, input logic [31:0] rdata);
    rst = r; RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; RDM = rd;
    ALUResultM = alu; WriteDataM = wd; dmem_ack = ack; dmem_rdata = rdata;
  endtask

  // Called at posedge+1: drive, check at negedge, return at next posedge+1.
  task automatic apply_vec(input vec_t v, input string tag);
    drive(v.rst, v.rw, v.rs, v.mw, v.rd, v.alu, v.wd, v.ack, v.rdata);
    @(negedge clk);
    chk({tag, "_req"}, 32'(dmem_req), 32'(v.e_req));
    chk({tag, "_stall"}, 32'(StallM), 32'(v.e_stall));
    chk({tag, "_we"}, 32'(dmem_we), 32'(v.e_we));
    chk({tag, "_addr"}, dmem_addr, v.e_addr);
    chk({tag, "_wdata"}, dmem_wdata, v.wd);
    chk({tag, "_regwrite"}, 32'(RegWriteW), 32'(v.e_rw));
    chk({tag, "_rdw"}, 32'(RDW), 32'(v.e_rd));
    chk({tag, "_result"}, ResultW, v.e_res);
    chk({tag, "_err"}, 32'(mem_err), 32'(v.e_err));
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[7];

  // Reference model state: completed request cycles of the pending access, plus W outputs.
  int          m_k = 0;
  logic        m_err = 1'b0, m_rw = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_res = 32'd0, m_last = 32'd0;

  initial begin
    logic        r, rw, rs, mw, ack, hold, e_req, e_abort, e_stall;
    logic [4:0]  rd;
    logic [31:0] alu, wd, rdata;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(posedge clk);
    #1;

    tbl[0] = mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h10, 32'd0, 1'b0, 32'd0,
                1'b0, 1'b0, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0);
    tbl[1] = tbl[0];
    tbl[2] = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'd0, 1'b0, 32'd0,
                1'b0, 1'b0, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0);
    tbl[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h5555, 32'd0, 1'b0, 32'd0,
                1'b0, 1'b0, 32'h5554, 1'b1, 5'd5, 32'h1234, 1'b0);
    tbl[4] = mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h103, 32'd0, 1'b1, 32'hDEADBEEF,
                1'b1, 1'b0, 32'h100, 1'b0, 5'd0, 32'h5555, 1'b0);
    tbl[5] = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h42, 32'd0, 1'b1, 32'h11111111,
                1'b0, 1'b0, 32'h40, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    tbl[6] = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h8, 32'd0, 1'b0, 32'd0,
                1'b0, 1'b0, 32'h8, 1'b0, 5'd3, 32'h42, 1'b0);
    for (int i = 0; i < 7; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    // Load with three wait cycles, then a store with two.
    apply_vec(mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h300, 32'd0, 1'b0, 32'd0,
                 1'b1, 1'b1, 32'h300, 1'b1, 5'd9, 32'h8, 1'b0), "ld3_c1");
    for (int i = 2; i <= 3; i++)
      apply_vec(mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h300, 32'd0, 1'b0, 32'd0,
                   1'b1, 1'b1, 32'h300, 1'b0, 5'd9, 32'h8, 1'b0), $sformatf("ld3_c%0d", i));
    apply_vec(mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h300, 32'd0, 1'b1, 32'hCAFEF00D,
                 1'b1, 1'b0, 32'h300, 1'b0, 5'd9, 32'h8, 1'b0), "ld3_ack");
    apply_vec(mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h400, 32'hA5A5A5A5, 1'b0, 32'd0,
                 1'b1, 1'b1, 32'h400, 1'b1, 5'd12, 32'hCAFEF00D, 1'b0), "st_c1");
    apply_vec(mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h400, 32'hA5A5A5A5, 1'b0, 32'd0,
                 1'b1, 1'b1, 32'h400, 1'b0, 5'd12, 32'hCAFEF00D, 1'b0), "st_c2");
    apply_vec(mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h400, 32'hA5A5A5A5, 1'b1, 32'h0BADF00D,
                 1'b1, 1'b0, 32'h400, 1'b0, 5'd12, 32'hCAFEF00D, 1'b0), "st_ack");

    // Load that never completes: four stall cycles, abort on the fifth request cycle.
    for (int i = 1; i <= 4; i++)
      apply_vec(mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd15, 32'h500, 32'd0, 1'b0, 32'd0,
                   1'b1, 1'b1, 32'h500, 1'b0, 5'd0, 32'h400, 1'b0), $sformatf("to_c%0d", i));
    apply_vec(mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd15, 32'h500, 32'd0, 1'b0, 32'd0,
                 1'b1, 1'b0, 32'h500, 1'b0, 5'd0, 32'h400, 1'b0), "to_abort");
    apply_vec(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h77, 32'd0, 1'b0, 32'd0,
                 1'b0, 1'b0, 32'h74, 1'b0, 5'd15, 32'h0BADF00D, 1'b1), "to_after");
    apply_vec(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0,
                 1'b0, 1'b0, 32'd0, 1'b1, 5'd6, 32'h77, 1'b1), "to_alu_wb");

    // Reset arriving while a load waits.
    apply_vec(mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h600, 32'd0, 1'b0, 32'd0,
                 1'b1, 1'b1, 32'h600, 1'b0, 5'd0, 32'd0, 1'b1), "rw_c1");
    apply_vec(mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'h600, 32'd0, 1'b0, 32'd0,
                 1'b0, 1'b0, 32'h600, 1'b0, 5'd0, 32'd0, 1'b1), "rw_rst");
    apply_vec(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'h9, 32'd0, 1'b0, 32'd0,
                 1'b0, 1'b0, 32'h8, 1'b0, 5'd0, 32'd0, 1'b0), "rw_after");

    // Random traffic; M inputs are frozen while the model says the pipeline is stalled.
    hold = 1'b0;
    rw = 1'b0; rs = 1'b0; mw = 1'b0; rd = 5'd0; alu = 32'd0; wd = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      r = (i < 2) ? 1'b0 : ($urandom_range(99) != 0);
      if (!hold) begin
        rw  = 1'($urandom);
        rs  = 1'($urandom);
        mw  = rs ? 1'b0 : ($urandom_range(3) == 0);
        rd  = 5'($urandom);
        alu = $urandom;
        wd  = $urandom;
      end
      ack   = ($urandom_range(9) < 4);
      rdata = $urandom;
      drive(r, rw, rs, mw, rd, alu, wd, ack, rdata);

      e_req   = r && (m_k > 0 || mw || rs);
      e_abort = r && (m_k > 0) && !ack && (TO != 0) && (m_k == TO);
      e_stall = e_req && !ack && !e_abort;

      @(negedge clk);
      chk("rnd_req", 32'(dmem_req), 32'(e_req));
      chk("rnd_stall", 32'(StallM), 32'(e_stall));
      chk("rnd_addr", dmem_addr, alu & 32'hFFFFFFFC);
      if (i > 0) begin
        chk("rnd_regwrite", 32'(RegWriteW), 32'(m_rw));
        chk("rnd_rdw", 32'(RDW), 32'(m_rd));
        chk("rnd_result", ResultW, m_res);
        chk("rnd_err", 32'(mem_err), 32'(m_err));
      end
      @(posedge clk);
      #1;

      if (!r) begin
        m_k = 0; m_err = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_res = 32'd0; m_last = 32'd0;
      end else if (e_stall) begin
        m_k++;
        m_rw = 1'b0;
      end else begin
        if (e_abort) m_err = 1'b1;
        m_k  = 0;
        m_rw = rw && (rd != 5'd0) && !(e_abort && rs);
        m_rd = rd;
        if (e_req && ack) m_last = rdata;
        m_res = rs ? m_last : alu;
      end
      hold = e_stall;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
